mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the MIPS datapath: replaces the single-cycle decoder and sequences fetch, decode, execute, memory and writeback over several clocks. It drives the same select/strobe nets that `ifu`, `alu`, `gpr`, `dm_4k`, `ext` and the writedata/writereg/ALU-B muxes consume. It adds `PcWrite`/`IrWrite` so the PC and instruction register update only in the proper state. One instruction is in flight at a time; `done` pulses as each instruction retires.

## Interface
Parameters:
- none.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `opcode`  in  6  instr[31:26] from the instruction register.
- `funct`  in  6  instr[5:0] from the instruction register.
- `zero`  in  1  ALU zero flag.
- `overflow`  in  1  ALU signed-overflow flag.
- `PcWrite`  out  1  PC load enable.
- `IrWrite`  out  1  instruction register load enable.
- `RegWrite`  out  1  GPR write strobe.
- `MemWrite`  out  1  data memory write strobe.
- `RegDst`  out  2  00 rt, 01 rd, 10 $31.
- `wd_sel`  out  2  00 AluOut, 01 readdata, 10 pcp4.
- `AluSrc`  out  1  0 rd2, 1 extout.
- `ExtOp`  out  2  00 zero-ext, 01 sign-ext, 10 imm16<<16.
- `AluCtrl`  out  4  0000 ADD, 0001 SUB, 0010 OR, 0011 SLT.
- `NpcSel`  out  3  000 pc+4, 001 branch, 010 j/jal, 011 jr.
- `done`  out  1  one-cycle pulse on the final cycle of each instruction.
- `illegal`  out  1  one-cycle pulse in DECODE for an unsupported opcode or funct.

## Operation
- Supported instructions:
  - R-type: addu (21), subu (23), slt (2A), jr (08).
  - I-type: ori (0D), lui (0F), lw (23), sw (2B), beq (04).
  - J-type: j (02), jal (03).
- States, 4-bit register: FETCH, DECODE, EXEC, MEMRD, MEMWR, WB, BRANCH, JUMP.
- FETCH: `IrWrite`=1, `PcWrite`=1, `NpcSel`=000. Next state is DECODE.
- DECODE:
  - Illegal opcode/funct: `illegal`=1, `done`=1, next FETCH. No writes.
  - beq → BRANCH.
  - j, jal, jr → JUMP.
  - All others → EXEC.
- EXEC: drives `AluSrc`/`ExtOp`/`AluCtrl` per instruction.
  - lw → MEMRD.
  - sw → MEMWR.
  - All others → WB.
- MEMRD: holds the EXEC ALU controls. Next state is WB.
- MEMWR: `MemWrite`=1, `done`=1. Next state is FETCH.
- WB: `RegWrite`=1, `done`=1. Next state is FETCH.
  - `RegDst`: 01 for R-type, 00 otherwise.
  - `wd_sel`: 01 for lw, 00 otherwise.
- BRANCH: `AluCtrl`=SUB, `AluSrc`=0, `ExtOp`=01, `NpcSel`=001, `PcWrite`=`zero`, `done`=1. Next state is FETCH.
- JUMP: `PcWrite`=1, `done`=1. Next state is FETCH.
  - `NpcSel`: 010 for j/jal, 011 for jr.
  - jal also drives `RegWrite`=1, `RegDst`=10, `wd_sel`=10.
- Per-instruction ALU setup:
  - addu/subu/slt: ADD/SUB/SLT, `AluSrc`=0.
  - ori: OR, `ExtOp`=00, `AluSrc`=1.
  - lui: OR, `ExtOp`=10, `AluSrc`=1, with `rs` assumed $0 by software.
  - lw/sw: ADD, `ExtOp`=01, `AluSrc`=1.
- Default values: every strobe and select not listed for a state is 0.
- Outputs are a pure function of the state register and the `opcode`/`funct` held in the IR. No combinational path from `zero` exists except to `PcWrite` in BRANCH.

## Timing
- Cycles per instruction (FETCH through the done state inclusive):
  - beq, j, jal, jr: 3.
  - R-type, ori, lui, sw: 4.
  - lw: 5.
  - illegal: 2.
- The IR and PC load on the FETCH clock edge. `opcode`/`funct` are valid from DECODE onward.
- Reset:
  - While `rst`=1 the state is FETCH and all outputs are 0, including `IrWrite`/`PcWrite`, which are gated by `~rst`.
  - The first FETCH executes on the first rising edge after `rst` deasserts.
- Reset mid-instruction: the state returns to FETCH immediately. Pending RegWrite/MemWrite strobes are dropped combinationally.
- beq with `zero`=0: `PcWrite`=0 and the PC keeps its FETCH-incremented value.

## Configuration
- `MC_ADD_OVF_EN` defined:
  - Also decodes add (funct 20) and addi (opcode 08).
  - add uses ALU ADD with `AluSrc`=0; addi uses ADD with `ExtOp`=01, `AluSrc`=1.
  - In WB, `RegWrite` = ~`overflow`, so the destination is left unchanged on signed overflow.
- `MC_ADD_OVF_EN` undefined: add and addi are illegal (`illegal` pulse, 2 cycles, no writes).

## Test plan
- Reset then addu $3,$1,$2 (opcode 00, funct 21):
  - States FETCH→DECODE→EXEC→WB.
  - `RegWrite`=1 and `RegDst`=01 only in cycle 4; `done` pulses in cycle 4.
- lw (opcode 23) then sw (opcode 2B):
  - lw takes 5 cycles: `wd_sel`=01 in WB, `MemWrite` never 1.
  - sw takes 4 cycles: `MemWrite`=1 only in MEMWR, `RegWrite` never 1.
- beq (opcode 04):
  - `zero`=1 gives `PcWrite`=1 with `NpcSel`=001 in cycle 3.
  - `zero`=0 gives `PcWrite`=0 in cycle 3.
  - Both cases take 3 cycles.
- jal (opcode 03):
  - Cycle 3 shows `PcWrite`=1, `NpcSel`=010, `RegWrite`=1, `RegDst`=10, `wd_sel`=10.
  - jr (funct 08) shows `NpcSel`=011 and `RegWrite`=0.
- Opcode 3F, then `rst` asserted asynchronously in EXEC of an ori:
  - Opcode 3F produces an `illegal` pulse in cycle 2, then FETCH.
  - The reset drops all outputs to 0 the same cycle, and the state is FETCH after release.
- With `MC_ADD_OVF_EN`, add with `overflow`=1 in WB: `RegWrite`=0, `done`=1. Without the macro, the same opcode gives an `illegal` pulse.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback.
// Optional MC_ADD_OVF_EN adds add/addi with writeback suppressed on signed overflow.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       PcWrite,
  output logic       IrWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] RegDst,
  output logic [1:0] wd_sel,
  output logic       AluSrc,
  output logic [1:0] ExtOp,
  output logic [3:0] AluCtrl,
  output logic [2:0] NpcSel,
  output logic       done,
  output logic       illegal
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSubu  = 6'h23;
  localparam logic [5:0] FnSlt   = 6'h2A;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluOr   = 4'b0010;
  localparam logic [3:0] AluSlt  = 4'b0011;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StExec,
    StMemrd,
    StMemwr,
    StWb,
    StBranch,
    StJump
  } state_e;

  state_e state_q;

  logic is_rtype, is_addu, is_subu, is_slt, is_jr, is_add;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_addi;
  logic legal, ovf_op;
  logic       ex_alu_src;
  logic [1:0] ex_ext_op;
  logic [3:0] ex_alu_ctrl;

  // Instruction decode from the IR fields.
  always_comb begin
    is_rtype = (opcode == OpRtype);
    is_addu  = is_rtype && (funct == FnAddu);
    is_subu  = is_rtype && (funct == FnSubu);
    is_slt   = is_rtype && (funct == FnSlt);
    is_jr    = is_rtype && (funct == FnJr);
    is_ori   = (opcode == OpOri);
    is_lui   = (opcode == OpLui);
    is_lw    = (opcode == OpLw);
    is_sw    = (opcode == OpSw);
    is_beq   = (opcode == OpBeq);
    is_j     = (opcode == OpJ);
    is_jal   = (opcode == OpJal);
`ifdef MC_ADD_OVF_EN
    is_add   = is_rtype && (funct == FnAdd);
    is_addi  = (opcode == OpAddi);
`else
    is_add   = 1'b0;
    is_addi  = 1'b0;
`endif
    ovf_op   = is_add | is_addi;
    legal    = is_addu | is_subu | is_slt | is_jr | is_add | is_ori | is_lui |
               is_lw | is_sw | is_beq | is_j | is_jal | is_addi;
  end

  // ALU setup shared by EXEC and MEMRD.
  always_comb begin
    ex_alu_src  = 1'b0;
    ex_ext_op   = 2'b00;
    ex_alu_ctrl = AluAdd;
    if (is_subu) begin
      ex_alu_ctrl = AluSub;
    end else if (is_slt) begin
      ex_alu_ctrl = AluSlt;
    end else if (is_ori) begin
      ex_alu_ctrl = AluOr;
      ex_alu_src  = 1'b1;
    end else if (is_lui) begin
      ex_alu_ctrl = AluOr;
      ex_ext_op   = 2'b10;
      ex_alu_src  = 1'b1;
    end else if (is_lw || is_sw || is_addi) begin
      ex_ext_op   = 2'b01;
      ex_alu_src  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch:  state_q <= StDecode;
        StDecode: begin
          if (!legal)                    state_q <= StFetch;
          else if (is_beq)               state_q <= StBranch;
          else if (is_j || is_jal || is_jr) state_q <= StJump;
          else                           state_q <= StExec;
        end
        StExec: begin
          if (is_lw)      state_q <= StMemrd;
          else if (is_sw) state_q <= StMemwr;
          else            state_q <= StWb;
        end
        StMemrd:  state_q <= StWb;
        default:  state_q <= StFetch;
      endcase
    end
  end

  // Outputs decode from state and IR; everything is forced low while in reset.
  always_comb begin
    PcWrite  = 1'b0;
    IrWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    RegDst   = 2'b00;
    wd_sel   = 2'b00;
    AluSrc   = 1'b0;
    ExtOp    = 2'b00;
    AluCtrl  = AluAdd;
    NpcSel   = 3'b000;
    done     = 1'b0;
    illegal  = 1'b0;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          IrWrite = 1'b1;
          PcWrite = 1'b1;
        end
        StDecode: begin
          if (!legal) begin
            illegal = 1'b1;
            done    = 1'b1;
          end
        end
        StExec, StMemrd: begin
          AluSrc  = ex_alu_src;
          ExtOp   = ex_ext_op;
          AluCtrl = ex_alu_ctrl;
        end
        StMemwr: begin
          MemWrite = 1'b1;
          done     = 1'b1;
        end
        StWb: begin
          RegWrite = ~(ovf_op & overflow);
          RegDst   = is_rtype ? 2'b01 : 2'b00;
          wd_sel   = is_lw ? 2'b01 : 2'b00;
          done     = 1'b1;
        end
        StBranch: begin
          AluCtrl = AluSub;
          ExtOp   = 2'b01;
          NpcSel  = 3'b001;
          PcWrite = zero;
          done    = 1'b1;
        end
        StJump: begin
          PcWrite = 1'b1;
          NpcSel  = is_jr ? 3'b011 : 3'b010;
          done    = 1'b1;
          if (is_jal) begin
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            wd_sel   = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed, cycle-by-cycle bench for mc_ctrl; expectations are hand-built output words.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, overflow;
  logic       PcWrite, IrWrite, RegWrite, MemWrite, AluSrc, done, illegal;
  logic [1:0] RegDst, wd_sel, ExtOp;
  logic [3:0] AluCtrl;
  logic [2:0] NpcSel;

  int ncmp  = 0;
  int nfail = 0;

  mc_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .funct    (funct),
    .zero     (zero),
    .overflow (overflow),
    .PcWrite  (PcWrite),
    .IrWrite  (IrWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .RegDst   (RegDst),
    .wd_sel   (wd_sel),
    .AluSrc   (AluSrc),
    .ExtOp    (ExtOp),
    .AluCtrl  (AluCtrl),
    .NpcSel   (NpcSel),
    .done     (done),
    .illegal  (illegal)
  );

  always #10 clk = ~clk;

  logic [19:0] act;
  assign act = {PcWrite, IrWrite, RegWrite, MemWrite, RegDst, wd_sel, AluSrc, ExtOp, AluCtrl,
                NpcSel, done, illegal};

  function automatic logic [19:0] ov(logic pcw, logic irw, logic rw, logic mw, logic [1:0] rd,
                                     logic [1:0] wd, logic as, logic [1:0] eo, logic [3:0] ac,
                                     logic [2:0] ns, logic dn, logic il);
    return {pcw, irw, rw, mw, rd, wd, as, eo, ac, ns, dn, il};
  endfunction

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        ovf;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[80];
  int   nv = 0;

  task automatic push(string n, logic r, logic [5:0] op, logic [5:0] fn, logic z, logic ovf,
                      logic [19:0] exp);
    vecs[nv].name = n;
    vecs[nv].rst  = r;
    vecs[nv].op   = op;
    vecs[nv].fn   = fn;
    vecs[nv].z    = z;
    vecs[nv].ovf  = ovf;
    vecs[nv].exp  = exp;
    nv++;
  endtask

  task automatic chk(string n, logic [19:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %05h expected %05h", n, act, exp);
    end
  endtask

  logic [19:0] z0, fetch, ill, ex_sub, ex_slt, ex_ori, ex_lui, ex_mem;
  logic [19:0] wb_r, wb_i, wb_lw, wb_nowr, memwr, br_t, br_f, jmp, jal, jr;

  initial begin
    z0      = '0;
    fetch   = ov(1, 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 4'd0, 3'd0, 0, 0);
    ill     = ov(0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 4'd0, 3'd0, 1, 1);
    ex_sub  = ov(0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 4'd1, 3'd0, 0, 0);
    ex_slt  = ov(0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 4'd3, 3'd0, 0, 0);
    ex_ori  = ov(0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd0, 4'd2, 3'd0, 0, 0);
    ex_lui  = ov(0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd2, 4'd2, 3'd0, 0, 0);
    ex_mem  = ov(0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd1, 4'd0, 3'd0, 0, 0);
    wb_r    = ov(0, 0, 1, 0, 2'd1, 2'd0, 0, 2'd0, 4'd0, 3'd0, 1, 0);
    wb_i    = ov(0, 0, 1, 0, 2'd0, 2'd0, 0, 2'd0, 4'd0, 3'd0, 1, 0);
    wb_lw   = ov(0, 0, 1, 0, 2'd0, 2'd1, 0, 2'd0, 4'd0, 3'd0, 1, 0);
    wb_nowr = ov(0, 0, 0, 0, 2'd1, 2'd0, 0, 2'd0, 4'd0, 3'd0, 1, 0);
    memwr   = ov(0, 0, 0, 1, 2'd0, 2'd0, 0, 2'd0, 4'd0, 3'd0, 1, 0);
    br_t    = ov(1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd1, 4'd1, 3'd1, 1, 0);
    br_f    = ov(0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd1, 4'd1, 3'd1, 1, 0);
    jmp     = ov(1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 4'd0, 3'd2, 1, 0);
    jal     = ov(1, 0, 1, 0, 2'd2, 2'd2, 0, 2'd0, 4'd0, 3'd2, 1, 0);
    jr      = ov(1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 4'd0, 3'd3, 1, 0);

    push("rst.a", 1, 6'h00, 6'h21, 1, 1, z0);
    push("rst.b", 1, 6'h00, 6'h21, 1, 1, z0);
    push("addu.c1", 0, 6'h00, 6'h21, 0, 0, fetch);
    push("addu.c2", 0, 6'h00, 6'h21, 0, 0, z0);
    push("addu.c3", 0, 6'h00, 6'h21, 0, 0, z0);
    push("addu.c4", 0, 6'h00, 6'h21, 0, 0, wb_r);
    push("subu.c1", 0, 6'h00, 6'h23, 0, 0, fetch);
    push("subu.c2", 0, 6'h00, 6'h23, 0, 0, z0);
    push("subu.c3", 0, 6'h00, 6'h23, 0, 0, ex_sub);
    push("subu.c4", 0, 6'h00, 6'h23, 0, 0, wb_r);
    push("slt.c1", 0, 6'h00, 6'h2A, 0, 0, fetch);
    push("slt.c2", 0, 6'h00, 6'h2A, 0, 0, z0);
    push("slt.c3", 0, 6'h00, 6'h2A, 0, 0, ex_slt);
    push("slt.c4", 0, 6'h00, 6'h2A, 0, 0, wb_r);
    push("ori.c1", 0, 6'h0D, 6'h00, 0, 0, fetch);
    push("ori.c2", 0, 6'h0D, 6'h00, 0, 0, z0);
    push("ori.c3", 0, 6'h0D, 6'h00, 0, 0, ex_ori);
    push("ori.c4", 0, 6'h0D, 6'h00, 0, 0, wb_i);
    push("lui.c1", 0, 6'h0F, 6'h00, 0, 0, fetch);
    push("lui.c2", 0, 6'h0F, 6'h00, 0, 0, z0);
    push("lui.c3", 0, 6'h0F, 6'h00, 0, 0, ex_lui);
    push("lui.c4", 0, 6'h0F, 6'h00, 0, 0, wb_i);
    push("lw.c1", 0, 6'h23, 6'h00, 0, 0, fetch);
    push("lw.c2", 0, 6'h23, 6'h00, 0, 0, z0);
    push("lw.c3", 0, 6'h23, 6'h00, 0, 0, ex_mem);
    push("lw.c4", 0, 6'h23, 6'h00, 0, 0, ex_mem);
    push("lw.c5", 0, 6'h23, 6'h00, 0, 0, wb_lw);
    push("sw.c1", 0, 6'h2B, 6'h00, 0, 0, fetch);
    push("sw.c2", 0, 6'h2B, 6'h00, 0, 0, z0);
    push("sw.c3", 0, 6'h2B, 6'h00, 0, 0, ex_mem);
    push("sw.c4", 0, 6'h2B, 6'h00, 0, 0, memwr);
    push("beqt.c1", 0, 6'h04, 6'h00, 1, 0, fetch);
    push("beqt.c2", 0, 6'h04, 6'h00, 1, 0, z0);
    push("beqt.c3", 0, 6'h04, 6'h00, 1, 0, br_t);
    push("beqf.c1", 0, 6'h04, 6'h00, 0, 0, fetch);
    push("beqf.c2", 0, 6'h04, 6'h00, 0, 0, z0);
    push("beqf.c3", 0, 6'h04, 6'h00, 0, 0, br_f);
    push("j.c1", 0, 6'h02, 6'h00, 0, 0, fetch);
    push("j.c2", 0, 6'h02, 6'h00, 0, 0, z0);
    push("j.c3", 0, 6'h02, 6'h00, 0, 0, jmp);
    push("jal.c1", 0, 6'h03, 6'h00, 0, 0, fetch);
    push("jal.c2", 0, 6'h03, 6'h00, 0, 0, z0);
    push("jal.c3", 0, 6'h03, 6'h00, 0, 0, jal);
    push("jr.c1", 0, 6'h00, 6'h08, 0, 0, fetch);
    push("jr.c2", 0, 6'h00, 6'h08, 0, 0, z0);
    push("jr.c3", 0, 6'h00, 6'h08, 0, 0, jr);
    push("op3f.c1", 0, 6'h3F, 6'h00, 0, 0, fetch);
    push("op3f.c2", 0, 6'h3F, 6'h00, 0, 0, ill);
    push("fn3f.c1", 0, 6'h00, 6'h3F, 0, 0, fetch);
    push("fn3f.c2", 0, 6'h00, 6'h3F, 0, 0, ill);
`ifdef MC_ADD_OVF_EN
    push("addov.c1", 0, 6'h00, 6'h20, 0, 1, fetch);
    push("addov.c2", 0, 6'h00, 6'h20, 0, 1, z0);
    push("addov.c3", 0, 6'h00, 6'h20, 0, 1, z0);
    push("addov.c4", 0, 6'h00, 6'h20, 0, 1, wb_nowr);
    push("add.c1", 0, 6'h00, 6'h20, 0, 0, fetch);
    push("add.c2", 0, 6'h00, 6'h20, 0, 0, z0);
    push("add.c3", 0, 6'h00, 6'h20, 0, 0, z0);
    push("add.c4", 0, 6'h00, 6'h20, 0, 0, wb_r);
    push("addi.c1", 0, 6'h08, 6'h00, 0, 0, fetch);
    push("addi.c2", 0, 6'h08, 6'h00, 0, 0, z0);
    push("addi.c3", 0, 6'h08, 6'h00, 0, 0, ex_mem);
    push("addi.c4", 0, 6'h08, 6'h00, 0, 0, wb_i);
`else
    push("addov.c1", 0, 6'h00, 6'h20, 0, 1, fetch);
    push("addov.c2", 0, 6'h00, 6'h20, 0, 1, ill);
    push("addi.c1", 0, 6'h08, 6'h00, 0, 0, fetch);
    push("addi.c2", 0, 6'h08, 6'h00, 0, 0, ill);
`endif
    push("ori2.c1", 0, 6'h0D, 6'h00, 0, 0, fetch);
    push("ori2.c2", 0, 6'h0D, 6'h00, 0, 0, z0);
    push("ori2.c3", 0, 6'h0D, 6'h00, 0, 0, ex_ori);

    rst      = 1'b1;
    opcode   = 6'h00;
    funct    = 6'h00;
    zero     = 1'b0;
    overflow = 1'b0;

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      rst      = vecs[i].rst;
      opcode   = vecs[i].op;
      funct    = vecs[i].fn;
      zero     = vecs[i].z;
      overflow = vecs[i].ovf;
      #1;
      chk(vecs[i].name, vecs[i].exp);
    end

    // Pulse reset between edges while ori sits in EXEC; the state must already be FETCH.
    #2 rst = 1'b1;
    #1 chk("midrst.zero", z0);
    #1 rst = 1'b0;
    #1 chk("midrst.fetch", fetch);
    @(negedge clk); #1 chk("midrst.c2", z0);
    @(negedge clk); #1 chk("midrst.c3", ex_ori);
    @(negedge clk); #1 chk("midrst.c4", wb_i);
    @(negedge clk); #1 chk("midrst.next", fetch);

    $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
    $finish;
  end

endmodule
